instruction_decode: RTL and testbench
=====================================

Name: instruction_decode

Overview:
Decode stage that sits directly downstream of instruction_fetch. It consumes the fetched instruction word, its PC and the fetch valid (ce) strobe, and splits RV32I instructions into register addresses, a sign-extended immediate, an ALU operation and control flags. All of these are held in a single registered pipeline stage. It forwards stall upstream to fetch and clears its own valid on flush.

Parameters:
IWIDTH, 32, instruction word width
PC_WIDTH, 32, program counter width
AWIDTH_REG, 5, register-file address width

Ports:
d_clk  input  1  clock; all state updates on rising edge
d_rst  input  1  reset, asynchronous, active-low
d_i_instr  input  IWIDTH  instruction from fetch (f_o_instr)
d_i_pc  input  PC_WIDTH  PC of that instruction (f_pc)
d_i_ce  input  1  fetch output valid (f_o_ce)
d_o_ce  output  1  decoded bundle valid for execute
d_i_stall  input  1  stall request from execute
d_o_stall  output  1  stall to fetch (f_i_stall)
d_i_flush  input  1  flush request from execute (taken branch/jump)
d_o_flush  output  1  flush to fetch (f_i_flush)
d_o_pc  output  PC_WIDTH  registered PC
d_o_addr_rs1  output  AWIDTH_REG  instr[19:15]
d_o_addr_rs2  output  AWIDTH_REG  instr[24:20]
d_o_addr_rd  output  AWIDTH_REG  instr[11:7]
d_o_imm  output  32  sign-extended immediate
d_o_funct3  output  3  instr[14:12]
d_o_opcode  output  7  instr[6:0]
d_o_alu_op  output  4  ALU operation code (package constant)
d_o_reg_write  output  1  instruction writes rd
d_o_mem_read  output  1  load
d_o_mem_write  output  1  store
d_o_illegal  output  1  unsupported or malformed encoding

Behaviour:
- Reset (d_rst=0, asynchronous): every registered output is 0, d_o_alu_op=ALU_ADD (0).
- d_o_stall = d_i_stall (combinational). d_o_flush = d_i_flush (combinational).
- Priority on each edge: reset > flush > stall > load.
- Flush (d_i_flush=1): d_o_ce<=0 and all control flags (reg_write, mem_read, mem_write, illegal) <=0. Datapath fields are don't-care.
- Stall (d_i_stall=1, no flush): every output register holds its value, including d_o_ce.
- Load (otherwise): d_o_ce<=d_i_ce.
  - If d_i_ce=1, all fields are decoded from d_i_instr and d_i_pc is registered into d_o_pc.
  - If d_i_ce=0, control flags <=0 (bubble).
- Latency: exactly 1 cycle from d_i_ce=1 to d_o_ce=1.
- Immediate selection by opcode:
  - I-type (0010011, 0000011, 1100111): imm = sext(instr[31:20])
  - S-type (0100011): imm = sext({instr[31:25], instr[11:7]})
  - B-type (1100011): imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - U-type (0110111, 0010111): imm = {instr[31:12], 12'b0}
  - J-type (1101111): imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - R-type and SYSTEM: imm = 0
- alu_op:
  - R-type: from funct3 plus instr[30]. SUB/SRA when instr[30]=1 on funct3 000/101.
  - OP-IMM: same as R-type, but instr[30] is only used for funct3=101 (SRAI). ADDI is never SUB.
  - Load, store, LUI, AUIPC, JAL, JALR: ALU_ADD.
  - Branch: funct3 000->ALU_EQ, 001->ALU_NEQ, 100->ALU_SLT, 101->ALU_GE, 110->ALU_SLTU, 111->ALU_GEU.
- reg_write = 1 for R, OP-IMM, load, LUI, AUIPC, JAL, JALR when rd != 0. It is forced to 0 when rd == 0 or illegal=1.
- Illegal (d_o_illegal=1, all other flags 0, d_o_ce still follows d_i_ce) when any of:
  - opcode is not in the RV32I set
  - R-type funct7 is not 0000000/0100000, or funct7=0100000 with funct3 not 000/101
  - branch funct3 is 010 or 011
  - load funct3 is 011, 110 or 111
  - store funct3 > 010
  - instr[1:0] != 11
- Simultaneous flush and stall: flush wins, so d_o_ce<=0.
- Reset asserted mid-stall: outputs clear immediately. After release the stage resumes with d_o_ce=0 until a new d_i_ce.

Decomposition:
- Package decode_pkg holds:
  - opcode constants (OPC_RTYPE, OPC_ITYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM)
  - 4-bit ALU codes: ALU_ADD=0, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, EQ, NEQ, GE, GEU
- One combinational sub-module, imm_gen (instruction in, 32-bit immediate out), reused by execute for verification cross-checks.

Test Plan:
- ADDI x1,x0,5 (0x00500093), ce=1 -> next cycle: ce=1, rd=1, rs1=0, imm=5, alu_op=ALU_ADD, reg_write=1, illegal=0.
- SUB x3,x1,x2 (0x402081B3) -> alu_op=ALU_SUB, rs1=1, rs2=2, rd=3, imm=0; ADDI x0,x0,0 (0x00000013) -> reg_write=0.
- BEQ x1,x2,-8 (0xFE208CE3) at pc=0x100 -> imm=0xFFFFFFF8, alu_op=ALU_EQ, reg_write=0, d_o_pc=0x100.
- Load 0x00500093, then hold d_i_stall=1 for 3 cycles while changing d_i_instr -> outputs frozen, d_o_stall=1 for those 3 cycles; release -> new instruction appears 1 cycle later.
- d_i_flush=1 together with d_i_stall=1 and d_i_ce=1 -> d_o_ce=0, reg_write=0 next cycle; d_o_flush=1 in the same cycle.
- 0xFFFFFFFF, then SW x2,4(x1) (0x0020A223) -> first: illegal=1, reg_write=0; second: mem_write=1, imm=4, illegal=0. Assert d_rst=0 mid-stream -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_decode_pkg.sv
// RV32I decode-stage constants, control bundle and ALU-op helper.
// Shared by decode, execute and their benches.
package decode_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic [3:0] ALU_NEQ  = 4'd11;
  localparam logic [3:0] ALU_GE   = 4'd12;
  localparam logic [3:0] ALU_GEU  = 4'd13;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic illegal;
  } ctrl_t;

  // alt selects SUB (funct3 000) or SRA (funct3 101)
  function automatic logic [3:0] alu_from_f3(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// Fetch->decode->execute bundle with valid/stall/flush handshake.
// dec is the decode side, exe the consumer side.
interface instruction_decode_if #(
  parameter int IWIDTH     = 32,
  parameter int PC_WIDTH   = 32,
  parameter int AWIDTH_REG = 5
);
  logic [IWIDTH-1:0]     instr;
  logic [PC_WIDTH-1:0]   pc_in;
  logic                  ce_in;
  logic                  ce;
  logic                  stall_in;
  logic                  stall;
  logic                  flush_in;
  logic                  flush;
  logic [PC_WIDTH-1:0]   pc;
  logic [AWIDTH_REG-1:0] rs1;
  logic [AWIDTH_REG-1:0] rs2;
  logic [AWIDTH_REG-1:0] rd;
  logic [31:0]           imm;
  logic [2:0]            funct3;
  logic [6:0]            opcode;
  logic [3:0]            alu_op;
  logic                  reg_write;
  logic                  mem_read;
  logic                  mem_write;
  logic                  illegal;

  modport dec (
    input  instr, pc_in, ce_in, stall_in, flush_in,
    output ce, stall, flush, pc, rs1, rs2, rd, imm,
    output funct3, opcode, alu_op,
    output reg_write, mem_read, mem_write, illegal
  );

  modport exe (
    output instr, pc_in, ce_in, stall_in, flush_in,
    input  ce, stall, flush, pc, rs1, rs2, rd, imm,
    input  funct3, opcode, alu_op,
    input  reg_write, mem_read, mem_write, illegal
  );
endinterface

// File: rtl/instruction_decode_imm_gen.sv
// RV32I immediate extraction, sign-extended to 32 bits.
// Purely combinational so execute can instantiate it for cross-checks.
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  logic [6:0] opc;
  assign opc = instr[6:0];

  always_comb begin
    imm = '0;
    unique case (1'b1)
      (opc == OPC_ITYPE),
      (opc == OPC_LOAD),
      (opc == OPC_JALR):
        imm = {{20{instr[31]}}, instr[31:20]};
      (opc == OPC_STORE):
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      (opc == OPC_BRANCH):
        imm = {{19{instr[31]}}, instr[31], instr[7],
               instr[30:25], instr[11:8], 1'b0};
      (opc == OPC_LUI),
      (opc == OPC_AUIPC):
        imm = {instr[31:12], 12'b0};
      (opc == OPC_JAL):
        imm = {{11{instr[31]}}, instr[31], instr[19:12],
               instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: one registered stage between fetch and execute.
// Priority per edge: reset > flush > stall > load.
module instruction_decode
  import decode_pkg::*;
#(
  parameter int IWIDTH     = 32,
  parameter int PC_WIDTH   = 32,
  parameter int AWIDTH_REG = 5
) (
  input  logic                  d_clk,
  input  logic                  d_rst,
  input  logic [IWIDTH-1:0]     d_i_instr,
  input  logic [PC_WIDTH-1:0]   d_i_pc,
  input  logic                  d_i_ce,
  output logic                  d_o_ce,
  input  logic                  d_i_stall,
  output logic                  d_o_stall,
  input  logic                  d_i_flush,
  output logic                  d_o_flush,
  output logic [PC_WIDTH-1:0]   d_o_pc,
  output logic [AWIDTH_REG-1:0] d_o_addr_rs1,
  output logic [AWIDTH_REG-1:0] d_o_addr_rs2,
  output logic [AWIDTH_REG-1:0] d_o_addr_rd,
  output logic [31:0]           d_o_imm,
  output logic [2:0]            d_o_funct3,
  output logic [6:0]            d_o_opcode,
  output logic [3:0]            d_o_alu_op,
  output logic                  d_o_reg_write,
  output logic                  d_o_mem_read,
  output logic                  d_o_mem_write,
  output logic                  d_o_illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [31:0] imm_w;
  logic [3:0] alu_w;
  ctrl_t ctrl_w;

  assign opc = d_i_instr[6:0];
  assign f3  = d_i_instr[14:12];
  assign f7  = d_i_instr[31:25];

  imm_gen u_imm (
    .instr (d_i_instr[31:0]),
    .imm   (imm_w)
  );

  logic wr_cand;
  logic bad;

  always_comb begin
    alu_w   = ALU_ADD;
    wr_cand = 1'b0;
    bad     = 1'b0;
    ctrl_w  = '0;
    unique case (1'b1)
      (opc == OPC_RTYPE): begin
        wr_cand = 1'b1;
        if (f7 == 7'b0000000)
          alu_w = alu_from_f3(f3, 1'b0);
        else if (f7 == 7'b0100000 &&
                 (f3 == 3'b000 || f3 == 3'b101))
          alu_w = alu_from_f3(f3, 1'b1);
        else
          bad = 1'b1;
      end
      (opc == OPC_ITYPE): begin
        wr_cand = 1'b1;
        alu_w = alu_from_f3(f3,
                  (f3 == 3'b101) && d_i_instr[30]);
      end
      (opc == OPC_LOAD): begin
        wr_cand = 1'b1;
        ctrl_w.mem_read = 1'b1;
        bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      (opc == OPC_STORE): begin
        ctrl_w.mem_write = 1'b1;
        bad = (f3 > 3'b010);
      end
      (opc == OPC_BRANCH): begin
        case (f3)
          3'b000:  alu_w = ALU_EQ;
          3'b001:  alu_w = ALU_NEQ;
          3'b100:  alu_w = ALU_SLT;
          3'b101:  alu_w = ALU_GE;
          3'b110:  alu_w = ALU_SLTU;
          3'b111:  alu_w = ALU_GEU;
          default: bad = 1'b1;
        endcase
      end
      (opc == OPC_JAL),
      (opc == OPC_JALR),
      (opc == OPC_LUI),
      (opc == OPC_AUIPC):
        wr_cand = 1'b1;
      (opc == OPC_SYSTEM): ;
      default:
        bad = 1'b1;
    endcase
    if (d_i_instr[1:0] != 2'b11)
      bad = 1'b1;
    if (bad) begin
      ctrl_w = '0;
      wr_cand = 1'b0;
    end
    ctrl_w.illegal = bad;
    ctrl_w.reg_write = wr_cand &&
      (d_i_instr[11:7] != 5'd0);
  end

  logic                  ce_q, ce_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [AWIDTH_REG-1:0] rs1_q, rs1_d;
  logic [AWIDTH_REG-1:0] rs2_q, rs2_d;
  logic [AWIDTH_REG-1:0] rd_q, rd_d;
  logic [31:0]           imm_q, imm_d;
  logic [2:0]            f3_q, f3_d;
  logic [6:0]            opc_q, opc_d;
  logic [3:0]            alu_q, alu_d;

  always_comb begin
    ce_d   = ce_q;
    ctrl_d = ctrl_q;
    pc_d   = pc_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    rd_d   = rd_q;
    imm_d  = imm_q;
    f3_d   = f3_q;
    opc_d  = opc_q;
    alu_d  = alu_q;
    if (d_i_flush) begin
      ce_d   = 1'b0;
      ctrl_d = '0;
    end else if (!d_i_stall) begin
      ce_d = d_i_ce;
      if (d_i_ce) begin
        ctrl_d = ctrl_w;
        pc_d   = d_i_pc;
        rs1_d  = d_i_instr[19:15];
        rs2_d  = d_i_instr[24:20];
        rd_d   = d_i_instr[11:7];
        imm_d  = imm_w;
        f3_d   = f3;
        opc_d  = opc;
        alu_d  = alu_w;
      end else begin
        ctrl_d = '0;
      end
    end
  end

  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      ce_q   <= 1'b0;
      ctrl_q <= '0;
      pc_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      imm_q  <= '0;
      f3_q   <= '0;
      opc_q  <= '0;
      alu_q  <= ALU_ADD;
    end else begin
      ce_q   <= ce_d;
      ctrl_q <= ctrl_d;
      pc_q   <= pc_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      rd_q   <= rd_d;
      imm_q  <= imm_d;
      f3_q   <= f3_d;
      opc_q  <= opc_d;
      alu_q  <= alu_d;
    end
  end

  assign d_o_stall     = d_i_stall;
  assign d_o_flush     = d_i_flush;
  assign d_o_ce        = ce_q;
  assign d_o_pc        = pc_q;
  assign d_o_addr_rs1  = rs1_q;
  assign d_o_addr_rs2  = rs2_q;
  assign d_o_addr_rd   = rd_q;
  assign d_o_imm       = imm_q;
  assign d_o_funct3    = f3_q;
  assign d_o_opcode    = opc_q;
  assign d_o_alu_op    = alu_q;
  assign d_o_reg_write = ctrl_q.reg_write;
  assign d_o_mem_read  = ctrl_q.mem_read;
  assign d_o_mem_write = ctrl_q.mem_write;
  assign d_o_illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode.
// Expected values are hand-decoded RV32I encodings.
module tb_instruction_decode;

  logic clk;
  logic rst_n;
  int checks;
  int failures;

  instruction_decode_if bus ();

  instruction_decode dut (
    .d_clk         (clk),
    .d_rst         (rst_n),
    .d_i_instr     (bus.instr),
    .d_i_pc        (bus.pc_in),
    .d_i_ce        (bus.ce_in),
    .d_o_ce        (bus.ce),
    .d_i_stall     (bus.stall_in),
    .d_o_stall     (bus.stall),
    .d_i_flush     (bus.flush_in),
    .d_o_flush     (bus.flush),
    .d_o_pc        (bus.pc),
    .d_o_addr_rs1  (bus.rs1),
    .d_o_addr_rs2  (bus.rs2),
    .d_o_addr_rd   (bus.rd),
    .d_o_imm       (bus.imm),
    .d_o_funct3    (bus.funct3),
    .d_o_opcode    (bus.opcode),
    .d_o_alu_op    (bus.alu_op),
    .d_o_reg_write (bus.reg_write),
    .d_o_mem_read  (bus.mem_read),
    .d_o_mem_write (bus.mem_write),
    .d_o_illegal   (bus.illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] ADDI1 = 32'h00500093;
  localparam logic [31:0] SUB3  = 32'h402081B3;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] BEQ   = 32'hFE208CE3;
  localparam logic [31:0] SW    = 32'h0020A223;
  localparam logic [31:0] ONES  = 32'hFFFFFFFF;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins,
                       input logic [31:0] pc,
                       input logic ce);
    bus.instr = ins;
    bus.pc_in = pc;
    bus.ce_in = ce;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.stall_in = 1'b0;
    bus.flush_in = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    #12;
    chk("rst_ce", 32'(bus.ce), 32'd0);
    chk("rst_alu", 32'(bus.alu_op), 32'd0);
    chk("rst_imm", bus.imm, 32'd0);
    chk("rst_rw", 32'(bus.reg_write), 32'd0);
    rst_n = 1'b1;

    // ADDI x1,x0,5
    drive(ADDI1, 32'h0, 1'b1);
    tick();
    chk("addi_ce", 32'(bus.ce), 32'd1);
    chk("addi_rd", 32'(bus.rd), 32'd1);
    chk("addi_rs1", 32'(bus.rs1), 32'd0);
    chk("addi_imm", bus.imm, 32'd5);
    chk("addi_alu", 32'(bus.alu_op), 32'd0);
    chk("addi_rw", 32'(bus.reg_write), 32'd1);
    chk("addi_ill", 32'(bus.illegal), 32'd0);
    chk("addi_opc", 32'(bus.opcode), 32'h13);

    // SUB x3,x1,x2
    drive(SUB3, 32'h4, 1'b1);
    tick();
    chk("sub_alu", 32'(bus.alu_op), 32'd1);
    chk("sub_rs1", 32'(bus.rs1), 32'd1);
    chk("sub_rs2", 32'(bus.rs2), 32'd2);
    chk("sub_rd", 32'(bus.rd), 32'd3);
    chk("sub_imm", bus.imm, 32'd0);

    // ADDI x0,x0,0: rd=0 suppresses write
    drive(NOP, 32'h8, 1'b1);
    tick();
    chk("nop_ce", 32'(bus.ce), 32'd1);
    chk("nop_rw", 32'(bus.reg_write), 32'd0);

    // BEQ x1,x2,-8 at 0x100
    drive(BEQ, 32'h100, 1'b1);
    tick();
    chk("beq_imm", bus.imm, 32'hFFFFFFF8);
    chk("beq_alu", 32'(bus.alu_op), 32'd10);
    chk("beq_rw", 32'(bus.reg_write), 32'd0);
    chk("beq_pc", bus.pc, 32'h100);

    // stall freezes outputs for 3 cycles
    drive(ADDI1, 32'h200, 1'b1);
    tick();
    bus.stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive((i == 1) ? NOP : SUB3, 32'h300 + 32'(i), 1'b1);
      #1;
      chk("stall_out", 32'(bus.stall), 32'd1);
      tick();
      chk("stall_rd", 32'(bus.rd), 32'd1);
      chk("stall_pc", bus.pc, 32'h200);
      chk("stall_ce", 32'(bus.ce), 32'd1);
    end
    drive(SUB3, 32'h300, 1'b1);
    bus.stall_in = 1'b0;
    tick();
    chk("unstall_rd", 32'(bus.rd), 32'd3);
    chk("unstall_pc", bus.pc, 32'h300);

    // flush beats stall
    drive(ADDI1, 32'h304, 1'b1);
    bus.flush_in = 1'b1;
    bus.stall_in = 1'b1;
    #1;
    chk("flush_out", 32'(bus.flush), 32'd1);
    tick();
    chk("flush_ce", 32'(bus.ce), 32'd0);
    chk("flush_rw", 32'(bus.reg_write), 32'd0);
    bus.flush_in = 1'b0;
    bus.stall_in = 1'b0;

    // illegal all-ones word, then SW x2,4(x1)
    drive(ONES, 32'h400, 1'b1);
    tick();
    chk("ill_flag", 32'(bus.illegal), 32'd1);
    chk("ill_rw", 32'(bus.reg_write), 32'd0);
    chk("ill_ce", 32'(bus.ce), 32'd1);
    drive(SW, 32'h404, 1'b1);
    tick();
    chk("sw_mw", 32'(bus.mem_write), 32'd1);
    chk("sw_imm", bus.imm, 32'd4);
    chk("sw_ill", 32'(bus.illegal), 32'd0);
    chk("sw_rs2", 32'(bus.rs2), 32'd2);

    // bubble clears flags
    drive(SW, 32'h408, 1'b0);
    tick();
    chk("bub_ce", 32'(bus.ce), 32'd0);
    chk("bub_mw", 32'(bus.mem_write), 32'd0);

    // reset mid-stall clears without a clock edge
    drive(ADDI1, 32'h500, 1'b1);
    tick();
    bus.stall_in = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ce", 32'(bus.ce), 32'd0);
    chk("arst_rd", 32'(bus.rd), 32'd0);
    chk("arst_imm", bus.imm, 32'd0);
    chk("arst_pc", bus.pc, 32'd0);
    chk("arst_rw", 32'(bus.reg_write), 32'd0);
    #3;
    rst_n = 1'b1;
    bus.stall_in = 1'b0;
    drive(ADDI1, 32'h600, 1'b0);
    tick();
    chk("post_ce0", 32'(bus.ce), 32'd0);
    drive(ADDI1, 32'h600, 1'b1);
    tick();
    chk("post_ce1", 32'(bus.ce), 32'd1);
    chk("post_pc", bus.pc, 32'h600);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
